// File: rtl/vliw_regfile.sv
// ---------------------------------------------------------------------------
// vliw_regfile
//   Multi-lane register file for a VLIW core. Each issue lane has two
//   combinational read ports and one write port. It also reports write-port
//   conflicts, meaning two or more enabled lanes writing the same nonzero
//   register in one cycle.
//
// Parameters
//   XLEN        data width of every register and port
//   NLANES      number of issue lanes
//   E_SUPPORTED 1 gives 16 architectural registers (address bit 4 ignored),
//               0 gives 32
//
// Optional feature
//   VLIW_RF_BYPASS_EN  When this macro is defined, a read whose address
//                      matches an enabled same-cycle nonzero write returns
//                      that write data. If several lanes write that register,
//                      the highest-numbered lane's data is returned.
//                      When the macro is undefined, reads return the array
//                      contents from before the edge.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   we3   [NLANES]           per-lane write enable
//   a1/a2 [5*NLANES]         per-lane read addresses, lane i at [5i+4:5i]
//   a3    [5*NLANES]         per-lane destination addresses
//   wd3   [XLEN*NLANES]      per-lane write data
//   rd1/rd2 [XLEN*NLANES]    per-lane read data
//   ConflictClr    synchronous clear of ConflictCount / ConflictSticky
//   ConflictW      combinational same-cycle write-conflict flag
//   ConflictSticky registered, set by any conflict cycle
//   ConflictCount  registered 8-bit saturating count of conflict cycles
//
// Handshake: there is no valid/ready. A write port with we3[i]=1 always
// commits at the next rising edge. The block never stalls and applies no
// back-pressure.
// ---------------------------------------------------------------------------
module vliw_regfile #(
    parameter int XLEN        = 32,
    parameter int NLANES      = 4,
    parameter int E_SUPPORTED = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NLANES-1:0]        we3,
    input  logic [5*NLANES-1:0]      a1,
    input  logic [5*NLANES-1:0]      a2,
    input  logic [5*NLANES-1:0]      a3,
    input  logic [XLEN*NLANES-1:0]   wd3,
    output logic [XLEN*NLANES-1:0]   rd1,
    output logic [XLEN*NLANES-1:0]   rd2,
    input  logic                     ConflictClr,
    output logic                     ConflictW,
    output logic                     ConflictSticky,
    output logic [7:0]               ConflictCount
);

    localparam int AW    = (E_SUPPORTED != 0) ? 4 : 5;
    localparam int NREGS = 1 << AW;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [7:0]      count_q, count_d;
    logic            sticky_q, sticky_d;

    // Effective (possibly truncated) per-lane addresses and write data
    logic [AW-1:0]   ra1 [NLANES];
    logic [AW-1:0]   ra2 [NLANES];
    logic [AW-1:0]   wa  [NLANES];
    logic [XLEN-1:0] wdl [NLANES];

    always_comb begin
        for (int i = 0; i < NLANES; i++) begin
            ra1[i] = a1[5*i +: AW];
            ra2[i] = a2[5*i +: AW];
            wa[i]  = a3[5*i +: AW];
            wdl[i] = wd3[XLEN*i +: XLEN];
        end
    end

    // Pairwise compare of enabled nonzero destinations.
    // Writes to x0 are discarded, so they can never conflict.
    always_comb begin
        ConflictW = 1'b0;
        for (int i = 0; i < NLANES; i++) begin
            for (int j = i + 1; j < NLANES; j++) begin
                if (we3[i] && we3[j] && (wa[i] != '0) && (wa[i] == wa[j])) begin
                    ConflictW = 1'b1;
                end
            end
        end
    end

    // The lanes are applied in ascending order, so the highest-numbered
    // lane writing a register overwrites the lower ones and wins.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NLANES; i++) begin
            if (we3[i] && (wa[i] != '0)) begin
                regs_d[wa[i]] = wdl[i];
            end
        end
        regs_d[0] = '0;
    end

    // A clear takes priority over an increment in the same cycle.
    always_comb begin
        count_d  = count_q;
        sticky_d = sticky_q | ConflictW;
        if (ConflictW && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
        if (ConflictClr) begin
            count_d  = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q   <= '{default: '0};
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    // Read ports. x0 is forced to zero. All read data is forced to zero
    // while reset is high, so no stale value leaves the block.
    always_comb begin
        logic [XLEN-1:0] v1;
        logic [XLEN-1:0] v2;
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < NLANES; i++) begin
            v1 = regs_q[ra1[i]];
            v2 = regs_q[ra2[i]];
`ifdef VLIW_RF_BYPASS_EN
            // Ascending scan, so the highest matching lane supplies the data.
            for (int j = 0; j < NLANES; j++) begin
                if (we3[j] && (wa[j] != '0) && (wa[j] == ra1[i])) v1 = wdl[j];
                if (we3[j] && (wa[j] != '0) && (wa[j] == ra2[i])) v2 = wdl[j];
            end
`endif
            if (reset || (ra1[i] == '0)) v1 = '0;
            if (reset || (ra2[i] == '0)) v2 = '0;
            rd1[XLEN*i +: XLEN] = v1;
            rd2[XLEN*i +: XLEN] = v2;
        end
    end

    assign ConflictCount  = count_q;
    assign ConflictSticky = sticky_q;

endmodule

// File: tb/tb_vliw_regfile.sv
module tb_vliw_regfile;

    localparam int XLEN = 32;
    localparam int NL   = 4;
    localparam int E    = 0;

    logic                 clk;
    logic                 reset;
    logic [NL-1:0]        we3;
    logic [5*NL-1:0]      a1, a2, a3;
    logic [XLEN*NL-1:0]   wd3;
    logic [XLEN*NL-1:0]   rd1, rd2;
    logic                 clr;
    logic                 cw, cs;
    logic [7:0]           cc;

    int errors = 0;
    int checks = 0;

    // Reference state: architectural registers and the conflict statistics
    logic [XLEN-1:0] mem [32];
    int              m_count;
    bit              m_sticky;

    vliw_regfile #(.XLEN(XLEN), .NLANES(NL), .E_SUPPORTED(E)) dut (
        .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3),
        .wd3(wd3), .rd1(rd1), .rd2(rd2), .ConflictClr(clr),
        .ConflictW(cw), .ConflictSticky(cs), .ConflictCount(cc)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] eff(input logic [4:0] a);
        return (E != 0) ? {1'b0, a[3:0]} : a;
    endfunction

    function automatic logic [4:0] lane_a3(input int j);
        return eff(a3[5*j +: 5]);
    endfunction

    function automatic logic [XLEN-1:0] lane_wd(input int j);
        return wd3[XLEN*j +: XLEN];
    endfunction

    // Conflict: some nonzero register has two or more enabled writers
    function automatic bit model_conflict();
        int n [32];
        foreach (n[k]) n[k] = 0;
        for (int j = 0; j < NL; j++)
            if (we3[j] && lane_a3(j) != 0) n[lane_a3(j)]++;
        foreach (n[k]) if (n[k] >= 2) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] model_read(input logic [4:0] a);
        logic [4:0] ea;
        ea = eff(a);
        if (reset || ea == 0) return '0;
`ifdef VLIW_RF_BYPASS_EN
        for (int j = NL - 1; j >= 0; j--)
            if (we3[j] && lane_a3(j) == ea) return lane_wd(j);
`endif
        return mem[ea];
    endfunction

    task automatic set_idle();
        we3 = '0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; clr = 1'b0;
    endtask

    task automatic set_wr(input int lane, input logic [4:0] addr, input logic [31:0] data);
        we3[lane] = 1'b1;
        a3[5*lane +: 5] = addr;
        wd3[XLEN*lane +: XLEN] = data;
    endtask

    // One cycle: check combinational outputs, advance the model at the
    // edge, then check the registered outputs.
    task automatic run_cycle();
        bit conf;
        #1;
        if (reset) begin
            foreach (mem[k]) mem[k] = '0;
            m_count  = 0;
            m_sticky = 1'b0;
        end
        conf = model_conflict();
        check("conflict_w", {31'd0, cw}, {31'd0, conf});
        for (int i = 0; i < NL; i++) begin
            check($sformatf("rd1_lane%0d", i), rd1[XLEN*i +: XLEN], model_read(a1[5*i +: 5]));
            check($sformatf("rd2_lane%0d", i), rd2[XLEN*i +: XLEN], model_read(a2[5*i +: 5]));
        end
        @(posedge clk);
        if (!reset) begin
            // The highest-numbered writer wins: the first one found scanning down.
            for (int r = 1; r < 32; r++) begin
                for (int j = NL - 1; j >= 0; j--) begin
                    if (we3[j] && lane_a3(j) == r) begin
                        mem[r] = lane_wd(j);
                        break;
                    end
                end
            end
            if (clr) begin
                m_count  = 0;
                m_sticky = 1'b0;
            end else if (conf) begin
                m_count  = (m_count < 255) ? m_count + 1 : 255;
                m_sticky = 1'b1;
            end
        end
        #1;
        check("conflict_count", {24'd0, cc}, m_count[31:0]);
        check("conflict_sticky", {31'd0, cs}, {31'd0, m_sticky});
    endtask

    initial begin
        foreach (mem[k]) mem[k] = '0;
        m_count  = 0;
        m_sticky = 1'b0;
        set_idle();
        reset = 1'b1;

        // Writes while reset is high are ignored and all reads stay zero.
        #2;
        set_wr(0, 5'd4, 32'hCAFE0001);
        a1[4:0] = 5'd4;
        run_cycle();
        run_cycle();
        reset = 1'b0;
        set_idle();

        // After reset, every register reads zero on all lanes.
        for (int k = 1; k < 32; k++) begin
            for (int i = 0; i < NL; i++) begin
                a1[5*i +: 5] = k[4:0];
                a2[5*i +: 5] = 5'(32 - k);
            end
            run_cycle();
        end
        check("reset_count", {24'd0, cc}, 32'd0);

        // Two lanes write distinct registers in the same cycle.
        set_idle();
        set_wr(0, 5'd5, 32'hDEADBEEF);
        set_wr(3, 5'd6, 32'h12345678);
        #1 check("distinct_no_conflict", {31'd0, cw}, 32'd0);
        run_cycle();
        set_idle();
        a1[5 +: 5] = 5'd5;
        a2[5 +: 5] = 5'd6;
        #1;
        check("lane1_rd1_x5", rd1[XLEN +: XLEN], 32'hDEADBEEF);
        check("lane1_rd2_x6", rd2[XLEN +: XLEN], 32'h12345678);
        run_cycle();

        // Two lanes write the same register; the higher lane wins.
        set_idle();
        set_wr(1, 5'd7, 32'h11);
        set_wr(2, 5'd7, 32'h22);
        #1 check("same_dest_conflict", {31'd0, cw}, 32'd1);
        run_cycle();
        check("count_after_one", {24'd0, cc}, 32'd1);
        check("sticky_after_one", {31'd0, cs}, 32'd1);
        set_idle();
        a1[4:0] = 5'd7;
        #1 check("x7_high_lane_wins", rd1[XLEN-1:0], 32'h22);
        run_cycle();

        // All lanes write x0: discarded, and no conflict is raised.
        set_idle();
        for (int i = 0; i < NL; i++) set_wr(i, 5'd0, 32'hFFFFFFFF);
        #1 check("x0_no_conflict", {31'd0, cw}, 32'd0);
        run_cycle();
        set_idle();
        #1 check("x0_reads_zero", rd1[XLEN-1:0], 32'd0);
        run_cycle();

        // The conflict count saturates, and a clear beats a same-cycle increment.
        for (int n = 0; n < 300; n++) begin
            set_idle();
            set_wr(0, 5'd3, $urandom);
            set_wr(1, 5'd3, $urandom);
            run_cycle();
        end
        check("count_saturated", {24'd0, cc}, 32'd255);
        set_idle();
        set_wr(2, 5'd3, 32'h1);
        set_wr(3, 5'd3, 32'h2);
        clr = 1'b1;
        #1 check("conflict_with_clear", {31'd0, cw}, 32'd1);
        run_cycle();
        check("count_cleared", {24'd0, cc}, 32'd0);
        check("sticky_cleared", {31'd0, cs}, 32'd0);

        // Same-cycle read of a register being written.
        set_idle();
        set_wr(1, 5'd9, 32'h77);
        run_cycle();
        set_idle();
        set_wr(0, 5'd9, 32'hA5);
        a1[10 +: 5] = 5'd9;
        #1;
`ifdef VLIW_RF_BYPASS_EN
        check("bypass_x9", rd1[2*XLEN +: XLEN], 32'hA5);
`else
        check("no_bypass_x9", rd1[2*XLEN +: XLEN], 32'h77);
`endif
        run_cycle();

        // Random traffic with occasional clears and one reset pulse.
        for (int n = 0; n < 250; n++) begin
            set_idle();
            for (int i = 0; i < NL; i++) begin
                we3[i] = 1'($urandom_range(0, 1));
                a1[5*i +: 5] = 5'($urandom_range(0, 31));
                a2[5*i +: 5] = 5'($urandom_range(0, 7));
                a3[5*i +: 5] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3))
                                                            : 5'($urandom_range(0, 31));
                wd3[XLEN*i +: XLEN] = $urandom;
            end
            clr = ($urandom_range(0, 15) == 0);
            reset = (n == 120 || n == 121);
            run_cycle();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
